// File: rtl/dmem_responder.sv
// dmem_responder: single-port data-memory responder with a valid/ready request
// channel and a valid/ready response channel. One request is in flight at a time.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, then performs its
// access on the first edge spent in RESP and holds the response until consumed.
// Optional feature macro: DMEM_ERR_CHECK_EN -- when defined, misaligned or
// out-of-range addresses are rejected with rsp_err=1 and no memory side effect.
// When undefined, addr[1:0] is ignored and addresses wrap modulo 4*DEPTH_WORDS.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rvld_q, rvld_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          acc_err;
  logic          do_access;
  logic          do_write;

  assign idx = addr_q[AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
  // Any set bit above the word index means addr >= 4*DEPTH_WORDS.
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);
`else
  // Byte offset and high address bits are deliberately dropped (wrap-around).
  logic unused_addr;
  assign unused_addr = ^{addr_q[31:AW+2], addr_q[1:0]};
  assign acc_err     = 1'b0;
`endif

  // The access happens exactly once: on the first edge spent in RESP.
  assign do_access = (state_q == RESP) && !rvld_q;
  assign do_write  = do_access && we_q && !acc_err;

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_valid = rvld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // State and captured-request registers; reset discards any pending access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: capture on acceptance, count the wait, respond, handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rvld_d  = rvld_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = '0;
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q + 4'd1 == LAT) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (!rvld_q) begin
          rvld_d  = 1'b1;
          err_d   = acc_err;
          rdata_d = (we_q || acc_err) ? 32'h0 : mem[idx];
        end else if (rsp_ready) begin
          rvld_d  = 1'b0;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Byte-masked store; memory contents are never reset.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
